icache_fetch_ctrl: RTL and testbench

- Direct-mapped instruction-cache controller between the CPU fetch stage and the 128-bit-line instruction memory.
- Hits return a 32-bit instruction in the same cycle.
- Misses stall the CPU and run a refill FSM that requests the 16-byte line from memory and waits for the line-valid handshake.
- Provides flush and saturating hit/miss counters for performance monitoring.

---
 rtl/icache_fetch_ctrl_if.sv | 31 +++
 rtl/icache_fetch_ctrl.sv | 134 +++++++++++++
 tb/tb_icache_fetch_ctrl.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/icache_fetch_ctrl_if.sv
// Fetch/memory bus for the instruction-cache controller.
//   CPU side   : cpu_req, pc, flush -> ; <- instr, instr_valid, stall
//   Memory side: <- mem_req, mem_addr ; mem_line, mem_line_valid ->
//   Monitoring : <- hit_count, miss_count
// master = environment (fetch stage + instruction memory), slave = controller.
interface icache_fetch_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             cpu_req;
  logic [31:0]      pc;
  logic             flush;
  logic [31:0]      instr;
  logic             instr_valid;
  logic             stall;
  logic             mem_req;
  logic [31:0]      mem_addr;
  logic [127:0]     mem_line;
  logic             mem_line_valid;
  logic [CNT_W-1:0] hit_count;
  logic [CNT_W-1:0] miss_count;

  modport master (
    output cpu_req, pc, flush, mem_line, mem_line_valid,
    input  instr, instr_valid, stall, mem_req, mem_addr, hit_count, miss_count
  );

  modport slave (
    input  cpu_req, pc, flush, mem_line, mem_line_valid,
    output instr, instr_valid, stall, mem_req, mem_addr, hit_count, miss_count
  );
endinterface

// File: rtl/icache_fetch_ctrl.sv
// Direct-mapped instruction-cache controller.
// Hits return a 32-bit word combinationally; a miss stalls the CPU while a
// three-state FSM (IDLE/REFILL/FILL_WAIT) fetches the 16-byte line.
// Ports:
//   clk    - rising-edge clock
//   rst_n  - synchronous active-low reset
//   bus    - icache_fetch_ctrl_if.slave (CPU fetch, memory refill, counters)
module icache_fetch_ctrl #(
  parameter int NUM_LINES = 16,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  icache_fetch_ctrl_if.slave   bus
);
  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int TAG_W = 28 - IDX_W;

  typedef enum logic [1:0] {IDLE, REFILL, FILL_WAIT} state_e;

  state_e                 state_q, state_d;
  logic [NUM_LINES-1:0]   valid_q, valid_d;
  logic [TAG_W-1:0]       tag_q  [NUM_LINES];
  logic [127:0]           data_q [NUM_LINES];
  logic [27:0]            line_addr_q, line_addr_d;
  logic [CNT_W-1:0]       hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;

  // address split of the live pc
  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag;
  logic [1:0]       word;
  assign idx  = bus.pc[4+IDX_W-1:4];
  assign tag  = bus.pc[31:4+IDX_W];
  assign word = bus.pc[3:2];

  logic unused_pc;
  assign unused_pc = ^bus.pc[1:0];

  // refill target always comes from the latched line address, not the pc
  logic [IDX_W-1:0] fill_idx;
  logic [TAG_W-1:0] fill_tag;
  assign fill_idx = line_addr_q[IDX_W-1:0];
  assign fill_tag = line_addr_q[27:IDX_W];

  logic lookup, hit, miss, fill;
  assign lookup = (state_q == IDLE) && bus.cpu_req && !bus.flush;
  assign hit    = lookup && valid_q[idx] && (tag_q[idx] == tag);
  assign miss   = lookup && !hit;
  // a flush in REFILL wins over a simultaneous line return
  assign fill   = (state_q == REFILL) && bus.mem_line_valid && !bus.flush;

  // state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      valid_q     <= '0;
      line_addr_q <= '0;
      hit_cnt_q   <= '0;
      miss_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      valid_q     <= valid_d;
      line_addr_q <= line_addr_d;
      hit_cnt_q   <= hit_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
    end
  end

  // line storage needs no reset; validity is tracked by valid_q
  always_ff @(posedge clk) begin
    if (rst_n && fill) begin
      tag_q[fill_idx]  <= fill_tag;
      data_q[fill_idx] <= bus.mem_line;
    end
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (miss) state_d = REFILL;
      REFILL:    if (bus.flush) state_d = IDLE;
                 else if (bus.mem_line_valid) state_d = FILL_WAIT;
      FILL_WAIT: state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // datapath next-state: valid bits, miss address, saturating counters
  always_comb begin
    valid_d     = valid_q;
    line_addr_d = line_addr_q;
    hit_cnt_d   = hit_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    if (bus.flush)  valid_d = '0;
    else if (fill)  valid_d[fill_idx] = 1'b1;
    if (miss)       line_addr_d = bus.pc[31:4];
    if (hit  && hit_cnt_q  != '1) hit_cnt_d  = hit_cnt_q  + CNT_W'(1);
    if (miss && miss_cnt_q != '1) miss_cnt_d = miss_cnt_q + CNT_W'(1);
  end

  // outputs
  logic [127:0] sel_line;
  assign sel_line = data_q[idx];

  always_comb begin
    bus.instr       = '0;
    bus.instr_valid = hit;
    bus.stall       = 1'b0;
    bus.mem_req     = 1'b0;
    bus.mem_addr    = '0;
    if (hit) begin
      case (word)
        2'd0:    bus.instr = sel_line[127:96];
        2'd1:    bus.instr = sel_line[95:64];
        2'd2:    bus.instr = sel_line[63:32];
        default: bus.instr = sel_line[31:0];
      endcase
    end
    case (state_q)
      // a request that is not served (miss or flush cycle) must be held
      IDLE:      bus.stall = bus.cpu_req && !hit;
      REFILL: begin
        bus.stall    = 1'b1;
        bus.mem_req  = 1'b1;
        bus.mem_addr = {line_addr_q, 4'b0};
      end
      default:   bus.stall = 1'b1;
    endcase
  end

  assign bus.hit_count  = hit_cnt_q;
  assign bus.miss_count = miss_cnt_q;
endmodule

// File: tb/tb_icache_fetch_ctrl.sv
module tb_icache_fetch_ctrl;
  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  icache_fetch_ctrl_if #(.CNT_W(CNT_W)) ifc ();
  icache_fetch_ctrl #(.NUM_LINES(16), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc)
  );

  int total = 0;
  int bad = 0;
  int exp_hit = 0;
  int exp_miss = 0;
  logic [31:0] exp_q[$];
  logic [127:0] line_a, line_b, line_c, line_d;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int sat(input int v);
    return (v >= CMAX) ? CMAX : v + 1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_cnt(input string tag);
    chk({tag, "_hits"}, 128'(ifc.hit_count), 128'(exp_hit));
    chk({tag, "_misses"}, 128'(ifc.miss_count), 128'(exp_miss));
  endtask

  // scoreboard: every delivered instruction is matched against the queue
  always @(negedge clk) begin
    if (rst_n && ifc.instr_valid) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $error("FAIL unexpected_instr observed=%0h expected=none", ifc.instr);
      end else begin
        chk("instr", 128'(ifc.instr), 128'(exp_q.pop_front()));
      end
    end
  end

  task automatic do_reset();
    rst_n = 1'b0;
    ifc.cpu_req = 1'b0;
    ifc.flush = 1'b0;
    ifc.mem_line_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    exp_hit = 0;
    exp_miss = 0;
  endtask

  task automatic do_hit(input logic [31:0] addr, input logic [31:0] word);
    ifc.cpu_req = 1'b1;
    ifc.pc = addr;
    exp_q.push_back(word);
    #2;
    chk("hit_stall", 128'(ifc.stall), 128'(0));
    chk("hit_valid", 128'(ifc.instr_valid), 128'(1));
    exp_hit = sat(exp_hit);
    tick();
    ifc.cpu_req = 1'b0;
  endtask

  // full miss: line returned L cycles after the first mem_req cycle
  task automatic do_miss(input logic [31:0] addr, input logic [127:0] line, input int lat,
                         input logic [31:0] word);
    ifc.cpu_req = 1'b1;
    ifc.pc = addr;
    exp_q.push_back(word);
    #2;
    chk("miss_stall", 128'(ifc.stall), 128'(1));
    chk("miss_valid", 128'(ifc.instr_valid), 128'(0));
    chk("miss_memreq", 128'(ifc.mem_req), 128'(0));
    exp_miss = sat(exp_miss);
    tick();
    for (int c = 1; c <= lat + 1; c++) begin
      ifc.mem_line = line;
      ifc.mem_line_valid = (c == lat + 1);
      #2;
      chk("refill_memreq", 128'(ifc.mem_req), 128'(1));
      chk("refill_addr", 128'(ifc.mem_addr), 128'({addr[31:4], 4'h0}));
      chk("refill_stall", 128'(ifc.stall), 128'(1));
      tick();
    end
    ifc.mem_line_valid = 1'b0;
    #2;
    chk("fillwait_memreq", 128'(ifc.mem_req), 128'(0));
    chk("fillwait_stall", 128'(ifc.stall), 128'(1));
    tick();
    #2;
    chk("relookup_stall", 128'(ifc.stall), 128'(0));
    chk("relookup_valid", 128'(ifc.instr_valid), 128'(1));
    exp_hit = sat(exp_hit);
    tick();
    ifc.cpu_req = 1'b0;
  endtask

  initial begin
    line_a = {32'hA000_0000, 32'hA111_1111, 32'hA222_2222, 32'hA333_3333};
    line_b = {32'hB000_0000, 32'hB111_1111, 32'hB222_2222, 32'hB333_3333};
    line_c = {32'hC000_0000, 32'hC111_1111, 32'hC222_2222, 32'hC333_3333};
    line_d = {32'hD000_0000, 32'hD111_1111, 32'hD222_2222, 32'hD333_3333};
    ifc.cpu_req = 1'b0;
    ifc.pc = '0;
    ifc.flush = 1'b0;
    ifc.mem_line = '0;
    ifc.mem_line_valid = 1'b0;

    // reset state
    tick();
    tick();
    #2;
    chk("rst_instr", 128'(ifc.instr), 128'(0));
    chk("rst_valid", 128'(ifc.instr_valid), 128'(0));
    chk("rst_stall", 128'(ifc.stall), 128'(0));
    chk("rst_memreq", 128'(ifc.mem_req), 128'(0));
    chk("rst_memaddr", 128'(ifc.mem_addr), 128'(0));
    chk_cnt("rst");
    rst_n = 1'b1;
    tick();

    // cold miss, then same-line hits
    do_miss(32'h0000_0008, line_a, 4, 32'hA222_2222);
    chk_cnt("cold");
    do_hit(32'h0000_0000, 32'hA000_0000);
    do_hit(32'h0000_0004, 32'hA111_1111);
    do_hit(32'h0000_000C, 32'hA333_3333);
    chk_cnt("hits");
    chk("hits_count4", 128'(ifc.hit_count), 128'(4));

    // conflict eviction on index 0
    do_miss(32'h0000_0100, line_b, 2, 32'hB000_0000);
    do_miss(32'h0000_0000, line_a, 1, 32'hA000_0000);
    chk_cnt("conflict");
    chk("conflict_miss3", 128'(ifc.miss_count), 128'(3));

    // flush in REFILL together with mem_line_valid
    do_reset();
    ifc.cpu_req = 1'b1;
    ifc.pc = 32'h0000_0040;
    #2;
    chk("fl_miss_stall", 128'(ifc.stall), 128'(1));
    exp_miss = sat(exp_miss);
    tick();
    #2;
    chk("fl_memreq", 128'(ifc.mem_req), 128'(1));
    chk("fl_memaddr", 128'(ifc.mem_addr), 128'(32'h40));
    tick();
    ifc.mem_line = line_c;
    ifc.mem_line_valid = 1'b1;
    ifc.flush = 1'b1;
    tick();
    ifc.flush = 1'b0;
    ifc.mem_line_valid = 1'b0;
    ifc.cpu_req = 1'b0;
    #2;
    chk("fl_abort_memreq", 128'(ifc.mem_req), 128'(0));
    chk("fl_abort_stall", 128'(ifc.stall), 128'(0));
    tick();
    do_miss(32'h0000_0040, line_c, 0, 32'hC000_0000);
    chk_cnt("flush_refill");
    chk("flush_refill_miss2", 128'(ifc.miss_count), 128'(2));

    // reset during REFILL, late line return ignored
    ifc.cpu_req = 1'b1;
    ifc.pc = 32'h0000_0080;
    tick();
    #2;
    chk("rr_memreq", 128'(ifc.mem_req), 128'(1));
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    ifc.cpu_req = 1'b0;
    exp_hit = 0;
    exp_miss = 0;
    #2;
    chk("rr_memreq_off", 128'(ifc.mem_req), 128'(0));
    chk("rr_memaddr", 128'(ifc.mem_addr), 128'(0));
    chk("rr_stall", 128'(ifc.stall), 128'(0));
    chk_cnt("rr");
    ifc.mem_line = line_b;
    ifc.mem_line_valid = 1'b1;
    tick();
    ifc.mem_line_valid = 1'b0;
    #2;
    chk("rr_late_memreq", 128'(ifc.mem_req), 128'(0));
    tick();
    do_miss(32'h0000_0084, line_d, 1, 32'hD111_1111);
    do_miss(32'h0000_0040, line_c, 1, 32'hC000_0000);
    chk_cnt("rr_after");

    // flush in IDLE invalidates lines and suppresses the hit
    ifc.cpu_req = 1'b1;
    ifc.pc = 32'h0000_0040;
    ifc.flush = 1'b1;
    #2;
    chk("fi_valid", 128'(ifc.instr_valid), 128'(0));
    tick();
    ifc.flush = 1'b0;
    ifc.cpu_req = 1'b0;
    #2;
    chk_cnt("fi");
    tick();
    do_miss(32'h0000_0040, line_c, 2, 32'hC000_0000);
    chk_cnt("fi_after");

    // saturation of the hit counter
    for (int i = 0; i < 20; i++) do_hit(32'h0000_0044, 32'hC111_1111);
    #2;
    chk("sat_hits15", 128'(ifc.hit_count), 128'(15));
    chk_cnt("sat");

    tick();
    chk("queue_empty", 128'(exp_q.size()), 128'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
